nand_flash_responder: RTL and testbench
=======================================

NAND_FLASH_RESPONDER -- requirements
Module: nand_flash_responder

Interface
REQ-001 SHALL have parameter PAGE_BYTES, default 512, bytes per page (column range 0..PAGE_BYTES-1).
REQ-002 SHALL have parameter PAGE_COUNT, default 16, pages in array; row address taken modulo PAGE_COUNT.
REQ-003 SHALL have parameter T_R, default 8, busy cycles after read address.
REQ-004 SHALL have parameter T_PROG, default 16, busy cycles after program confirm.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 F_IO  inout  8  data/command/address bus; driven only while output-enable asserted, else high-Z.
REQ-008 F_CLE  input  1  command latch enable.
REQ-009 F_ALE  input  1  address latch enable.
REQ-010 F_WEN  input  1  write enable, active-low; latch on rising edge.
REQ-011 F_REN  input  1  read enable, active-low; data launched on falling edge.
REQ-012 F_RB  output  1  ready(1)/busy(0).

Function
REQ-013 SHALL register F_WEN/F_REN each clk; WEN rising edge = prev 0, now 1; REN falling edge = prev 1, now 0; F_IO sampled in the same cycle a WEN rising edge is detected.
REQ-014 SHALL use states IDLE, ADDR, BUSY_R, READ_OUT, PROG_DATA, BUSY_P.
REQ-015 Command latch = WEN rising edge with CLE=1, ALE=0; address latch = WEN rising edge with ALE=1, CLE=0; CLE=ALE=1 edge SHALL be ignored.
REQ-016 Command 0x00 SHALL set half=0, 0x01 half=1, 0x80 set mode=program; each -> ADDR, address count cleared.
REQ-017 ADDR SHALL accept exactly 3 address bytes: byte0 = column[7:0], byte1 = row[7:0], byte2 = row[15:8]; start column = half*256 + byte0 (0x80 uses half=0).
REQ-018 After 3rd address byte: read mode -> BUSY_R, F_RB=0 next cycle for exactly T_R cycles, then F_RB=1 and -> READ_OUT; program mode -> PROG_DATA, F_RB stays 1.
REQ-019 READ_OUT: each REN falling edge SHALL load output register with mem[row][col], assert output-enable from next cycle, col <= col+1; output-enable SHALL drop the cycle after REN returns high.
REQ-020 PROG_DATA: each data latch (WEN rising, CLE=ALE=0) SHALL write F_IO to mem[row][col], col <= col+1.
REQ-021 Column SHALL wrap from PAGE_BYTES-1 to 0 within same page, read and program.
REQ-022 Command 0x10 in PROG_DATA SHALL -> BUSY_P, F_RB=0 for exactly T_PROG cycles, then F_RB=1 -> IDLE.
REQ-023 Command 0xFF in any state SHALL abort to IDLE, F_RB=1, output-enable=0, col and address count cleared; bytes already written stay written.
REQ-024 Any other command, or 0x10 outside PROG_DATA, SHALL return to IDLE without memory change.
REQ-025 In BUSY_R/BUSY_P all WEN/REN edges except command 0xFF SHALL be ignored.
REQ-026 A new 0x00/0x01/0x80 command in READ_OUT SHALL start a new sequence (-> ADDR).
REQ-027 Address or data latch in IDLE SHALL be ignored.
REQ-028 Output-enable SHALL never assert outside READ_OUT.

Reset
REQ-029 rst SHALL force state IDLE, F_RB=1, output-enable=0 (F_IO high-Z), col=0, row=0, address count=0, busy counter=0, edge-detect registers=1.
REQ-030 Memory array contents SHALL NOT be cleared by rst.
REQ-031 rst mid-BUSY or mid-READ_OUT SHALL take effect next clock edge, overriding all other activity.

Verification
REQ-032 Program: 0x80, addr 0x05,0x03,0x00, data 0xA1,0xB2,0xC3, 0x10 -> F_RB low exactly 16 cycles; then 0x00, addr 0x05,0x03,0x00 -> F_RB low exactly 8 cycles; 3 REN pulses -> F_IO 0xA1,0xB2,0xC3.
REQ-033 Half select: program page 2 col 256 = 0x5A; command 0x01, addr 0x00,0x02,0x00 -> first read byte 0x5A.
REQ-034 Wrap: program page 1 col 510,511,0 = 0x11,0x22,0x33 via start col 510 (0x01, addr 0xFE) -> read back 0x11,0x22,0x33 from start col 510.
REQ-035 Abort: 0xFF at cycle 3 of BUSY_P -> F_RB=1 next cycle, state IDLE, F_IO high-Z; REN pulses drive nothing.
REQ-036 Ignore: WEN/REN toggles and CLE=ALE=1 edges during BUSY_R -> busy length still exactly 8, no memory change; rst during READ_OUT -> F_IO high-Z next cycle, F_RB=1, previously programmed data unchanged on re-read.

Source files
------------

// File: rtl/nand_flash_responder.sv
// NAND flash device model: command/address/data latching on WEN edges, page array,
// timed busy phases and REN-paced read-out on a shared tristate bus.
module nand_flash_responder #(
   parameter int unsigned PAGE_BYTES = 512,
   parameter int unsigned PAGE_COUNT = 16,
   parameter int unsigned T_R        = 8,
   parameter int unsigned T_PROG     = 16
) (
   input  logic       clk,
   input  logic       rst,
   inout  logic [7:0] F_IO,
   input  logic       F_CLE,
   input  logic       F_ALE,
   input  logic       F_WEN,
   input  logic       F_REN,
   output logic       F_RB
);

   localparam int unsigned CW    = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
   localparam int unsigned DEPTH = PAGE_BYTES * PAGE_COUNT;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {IDLE, ADDR, BUSY_R, READ_OUT, PROG_DATA, BUSY_P} state_t;

   state_t          state_q, state_d;
   logic            wen_q, ren_q;
   logic            half_q, half_d;
   logic            prog_q, prog_d;
   logic [CW-1:0]   col_q, col_d;
   logic [15:0]     row_q, row_d;
   logic [1:0]      acnt_q, acnt_d;
   logic [31:0]     busy_q, busy_d;
   logic            oe_q, oe_d;
   logic [7:0]      dout_q;
   logic [7:0]      mem [DEPTH];

   logic            wen_rise, ren_fall;
   logic            cmd_lat, adr_lat, dat_lat;
   logic [CW-1:0]   col_inc;
   logic [31:0]     page;
   logic [AW-1:0]   mem_addr;
   logic            mem_we, rd_en;

   assign wen_rise = ~wen_q & F_WEN;
   assign ren_fall = ren_q & ~F_REN;
   assign cmd_lat  = wen_rise & F_CLE & ~F_ALE;
   assign adr_lat  = wen_rise & F_ALE & ~F_CLE;
   assign dat_lat  = wen_rise & ~F_CLE & ~F_ALE;

   assign col_inc  = (col_q == CW'(PAGE_BYTES - 1)) ? '0 : col_q + CW'(1);
   assign page     = 32'(row_q) % PAGE_COUNT;
   assign mem_addr = AW'(page * PAGE_BYTES + 32'(col_q));

   assign F_IO = oe_q ? dout_q : 8'bz;
   assign F_RB = ~((state_q == BUSY_R) || (state_q == BUSY_P));

   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      prog_d  = prog_q;
      col_d   = col_q;
      row_d   = row_q;
      acnt_d  = acnt_q;
      busy_d  = busy_q;
      oe_d    = oe_q & ~F_REN;
      mem_we  = 1'b0;
      rd_en   = 1'b0;

      unique case (state_q)
         IDLE: ;
         ADDR: begin
            if (adr_lat) begin
               case (acnt_q)
                  2'd0: begin
                     col_d  = CW'(32'({half_q, F_IO}) % PAGE_BYTES);
                     acnt_d = 2'd1;
                  end
                  2'd1: begin
                     row_d[7:0] = F_IO;
                     acnt_d     = 2'd2;
                  end
                  default: begin
                     row_d[15:8] = F_IO;
                     acnt_d      = 2'd0;
                     if (prog_q) begin
                        state_d = PROG_DATA;
                     end else begin
                        state_d = BUSY_R;
                        busy_d  = 32'(T_R);
                     end
                  end
               endcase
            end
         end
         BUSY_R: begin
            if (busy_q <= 32'd1) begin
               state_d = READ_OUT;
               busy_d  = '0;
            end else begin
               busy_d = busy_q - 32'd1;
            end
         end
         READ_OUT: begin
            if (ren_fall) begin
               rd_en = 1'b1;
               oe_d  = 1'b1;
               col_d = col_inc;
            end
         end
         PROG_DATA: begin
            if (dat_lat) begin
               mem_we = 1'b1;
               col_d  = col_inc;
            end
         end
         BUSY_P: begin
            if (busy_q <= 32'd1) begin
               state_d = IDLE;
               busy_d  = '0;
            end else begin
               busy_d = busy_q - 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Commands override the per-state behaviour; only reset (0xFF) reaches a busy device.
      if (cmd_lat) begin
         if (F_IO == 8'hFF) begin
            state_d = IDLE;
            col_d   = '0;
            acnt_d  = '0;
            busy_d  = '0;
         end else if (state_q != BUSY_R && state_q != BUSY_P) begin
            case (F_IO)
               8'h00, 8'h01, 8'h80: begin
                  state_d = ADDR;
                  acnt_d  = '0;
                  half_d  = (F_IO == 8'h01);
                  prog_d  = (F_IO == 8'h80);
               end
               8'h10: begin
                  if (state_q == PROG_DATA) begin
                     state_d = BUSY_P;
                     busy_d  = 32'(T_PROG);
                  end else begin
                     state_d = IDLE;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end

      if (state_d != READ_OUT) oe_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wen_q   <= 1'b1;
         ren_q   <= 1'b1;
         half_q  <= 1'b0;
         prog_q  <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         acnt_q  <= '0;
         busy_q  <= '0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wen_q   <= F_WEN;
         ren_q   <= F_REN;
         half_q  <= half_d;
         prog_q  <= prog_d;
         col_q   <= col_d;
         row_q   <= row_d;
         acnt_q  <= acnt_d;
         busy_q  <= busy_d;
         oe_q    <= oe_d;
      end
   end

   // Array and read register are deliberately outside reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem[mem_addr] <= F_IO;
      if (rd_en) dout_q <= mem[mem_addr];
   end

endmodule

// File: tb/tb_nand_flash_responder.sv
// Self-checking bench for nand_flash_responder: directed protocol sequences, a decode
// vector table and randomized program/read traffic against a flat byte-array model.
module tb_nand_flash_responder;

   localparam int PB = 512;
   localparam int PC = 16;
   localparam int TR = 8;
   localparam int TP = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       F_CLE, F_ALE, F_WEN, F_REN;
   logic       F_RB;
   tri1  [7:0] F_IO;
   logic [7:0] drv;
   logic       drv_en;

   assign F_IO = drv_en ? drv : 8'bz;

   always #5 clk = ~clk;

   nand_flash_responder #(
      .PAGE_BYTES(PB),
      .PAGE_COUNT(PC),
      .T_R       (TR),
      .T_PROG    (TP)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .F_IO (F_IO),
      .F_CLE(F_CLE),
      .F_ALE(F_ALE),
      .F_WEN(F_WEN),
      .F_REN(F_REN),
      .F_RB (F_RB)
   );

   int checks = 0;
   int errors = 0;

   // Busy-length monitor: length of the most recent low run of F_RB.
   int run = 0;
   int last_busy = 0;
   int busy_events = 0;
   always @(negedge clk) begin
      if (F_RB === 1'b0) begin
         run <= run + 1;
      end else begin
         if (run != 0) begin
            last_busy   <= run;
            busy_events <= busy_events + 1;
         end
         run <= 0;
      end
   end

   // Reference model: flat byte array indexed by page and column.
   logic [7:0] mref [PC*PB];
   logic [7:0] pbuf [300];

   function automatic int midx(input int row, input int col);
      return (row % PC) * PB + (col % PB);
   endfunction

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wen_op(input logic cle, input logic ale, input logic [7:0] d);
      @(negedge clk);
      F_CLE = cle; F_ALE = ale; drv = d; drv_en = 1'b1; F_WEN = 1'b0;
      @(negedge clk);
      F_WEN = 1'b1;
      @(negedge clk);
      drv_en = 1'b0; F_CLE = 1'b0; F_ALE = 1'b0;
   endtask

   task automatic cmd(input logic [7:0] d);
      wen_op(1'b1, 1'b0, d);
   endtask

   task automatic addr3(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
      wen_op(1'b0, 1'b1, a0);
      wen_op(1'b0, 1'b1, a1);
      wen_op(1'b0, 1'b1, a2);
   endtask

   task automatic ren_op(output logic [7:0] v_on, output logic [7:0] v_off);
      @(negedge clk);
      F_REN = 1'b0;
      @(negedge clk);
      v_on  = F_IO;
      F_REN = 1'b1;
      @(negedge clk);
      v_off = F_IO;
   endtask

   task automatic read_chk(input string name, input logic [7:0] exp);
      logic [7:0] von, voff;
      ren_op(von, voff);
      chk8(name, von, exp);
      chk8({name, "_hiz"}, voff, 8'hFF);
   endtask

   task automatic wait_ready(input string name, input int ev0, input int exp_len);
      int n = 0;
      while (F_RB !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chki(name, (n < 1000 && busy_events == ev0 + 1) ? last_busy : -1, exp_len);
   endtask

   task automatic prog_seq(input logic [15:0] row, input logic [7:0] c0, input int len);
      int ev;
      cmd(8'h80);
      addr3(c0, row[7:0], row[15:8]);
      for (int i = 0; i < len; i++) begin
         wen_op(1'b0, 1'b0, pbuf[i]);
         mref[midx(int'(row), int'(c0) + i)] = pbuf[i];
      end
      ev = busy_events;
      cmd(8'h10);
      wait_ready("prog_busy", ev, TP);
   endtask

   task automatic read_seq(input string name, input logic [7:0] c, input logic [15:0] row,
                           input logic [7:0] c0, input int len);
      int ev;
      int start;
      start = (c == 8'h01) ? 256 + int'(c0) : int'(c0);
      cmd(c);
      ev = busy_events;
      addr3(c0, row[7:0], row[15:8]);
      wait_ready({name, "_busy"}, ev, TR);
      for (int i = 0; i < len; i++) read_chk(name, mref[midx(int'(row), start + i)]);
   endtask

   typedef struct {
      logic [7:0] c;
      logic [7:0] a0, a1, a2;
      int         busy;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] von, voff;
      int ev;

      vecs[0] = '{8'h00, 8'h05, 8'h03, 8'h00, TR, 8'hA1};
      vecs[1] = '{8'h00, 8'h06, 8'h13, 8'h00, TR, 8'hB2};
      vecs[2] = '{8'h00, 8'h07, 8'h03, 8'h01, TR, 8'hC3};
      vecs[3] = '{8'h01, 8'h00, 8'h02, 8'h00, TR, 8'h5A};
      vecs[4] = '{8'h00, 8'hFF, 8'h02, 8'h00, TR, 8'hEE};
      vecs[5] = '{8'h00, 8'h10, 8'h04, 8'h00, TR, 8'h77};
      vecs[6] = '{8'h01, 8'hFE, 8'h01, 8'h00, TR, 8'h11};
      vecs[7] = '{8'h00, 8'h00, 8'h01, 8'h00, TR, 8'h33};
      vecs[8] = '{8'h30, 8'h05, 8'h03, 8'h00, 0, 8'hFF};
      vecs[9] = '{8'h10, 8'h05, 8'h03, 8'h00, 0, 8'hFF};

      F_CLE = 0; F_ALE = 0; F_WEN = 1; F_REN = 1; drv = 0; drv_en = 0; rst = 1;
      repeat (3) @(negedge clk);
      chki("reset_rb", int'(F_RB), 1);
      chk8("reset_hiz", F_IO, 8'hFF);
      rst = 0;

      // Basic program then read-back.
      pbuf[0] = 8'hA1; pbuf[1] = 8'hB2; pbuf[2] = 8'hC3;
      prog_seq(16'h0003, 8'h05, 3);
      read_seq("basic", 8'h00, 16'h0003, 8'h05, 3);

      // Half select: col 255/256 of page 2, read from col 256 via 0x01.
      pbuf[0] = 8'hEE; pbuf[1] = 8'h5A;
      prog_seq(16'h0002, 8'hFF, 2);
      read_seq("half", 8'h01, 16'h0002, 8'h00, 1);

      // Column wrap: run from col 254 through 511 back to 0.
      for (int i = 0; i < 256; i++) pbuf[i] = 8'($urandom);
      pbuf[256] = 8'h11; pbuf[257] = 8'h22; pbuf[258] = 8'h33;
      prog_seq(16'h0001, 8'hFE, 259);
      read_seq("wrap", 8'h01, 16'h0001, 8'hFE, 3);

      // Abort during program busy.
      cmd(8'h80);
      addr3(8'h10, 8'h04, 8'h00);
      wen_op(1'b0, 1'b0, 8'h77);
      mref[midx(4, 16)] = 8'h77;
      ev = busy_events;
      cmd(8'h10);
      cmd(8'hFF);
      chki("abort_rb", int'(F_RB), 1);
      chk8("abort_hiz", F_IO, 8'hFF);
      ren_op(von, voff);
      chk8("abort_ren_on", von, 8'hFF);
      chk8("abort_ren_off", voff, 8'hFF);
      chki("abort_len", (busy_events == ev + 1) ? last_busy : -1, 3);

      // Activity during read busy must be ignored.
      cmd(8'h00);
      ev = busy_events;
      addr3(8'h05, 8'h03, 8'h00);
      ren_op(von, voff);
      wen_op(1'b0, 1'b0, 8'h99);
      wen_op(1'b1, 1'b1, 8'h00);
      wait_ready("ign_busy", ev, TR);
      for (int i = 0; i < 3; i++) read_chk("ign_data", mref[midx(3, 5 + i)]);

      // Reset in the middle of a read-out.
      cmd(8'h00);
      ev = busy_events;
      addr3(8'h05, 8'h03, 8'h00);
      wait_ready("rst_busy", ev, TR);
      @(negedge clk);
      F_REN = 1'b0;
      @(negedge clk);
      chk8("rst_pre", F_IO, 8'hA1);
      rst = 1'b1;
      @(negedge clk);
      chk8("rst_hiz", F_IO, 8'hFF);
      chki("rst_rb", int'(F_RB), 1);
      rst = 1'b0;
      F_REN = 1'b1;
      read_seq("reread", 8'h00, 16'h0003, 8'h05, 3);

      // Command decode table.
      for (int v = 0; v < 10; v++) begin
         cmd(vecs[v].c);
         ev = busy_events;
         addr3(vecs[v].a0, vecs[v].a1, vecs[v].a2);
         if (vecs[v].busy != 0) begin
            wait_ready($sformatf("vec%0d_busy", v), ev, vecs[v].busy);
         end else begin
            @(negedge clk);
            chki($sformatf("vec%0d_nobusy", v), busy_events - ev + 1 - int'(F_RB), 0);
         end
         ren_op(von, voff);
         chk8($sformatf("vec%0d_data", v), von, vecs[v].exp);
         chk8($sformatf("vec%0d_hiz", v), voff, 8'hFF);
      end

      // Randomized program/read traffic.
      for (int it = 0; it < 8; it++) begin
         logic [15:0] row;
         logic [7:0]  c0;
         int          len;
         row = 16'($urandom);
         c0  = 8'($urandom_range(0, 200));
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) pbuf[i] = 8'($urandom);
         prog_seq(row, c0, len);
         read_seq($sformatf("rand%0d", it), 8'h00, row, c0, len);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
